cacheline_arbiter: RTL and testbench
====================================

Name: cacheline_arbiter

Overview:
- Parametrised N-port cacheline memory arbiter between the L1 caches (instruction, data, optional extra ports) and the single physical-memory port.
- Arbitrates reads and writes round-robin and routes data per port.
- Optional one-line next-line prefetch buffer is attached to a designated port, normally the I-cache.
- Replaces the fixed two-port arbiter with its separate datapath/control split.

Parameters:
- NUM_PORTS, 2, number of requesting caches (2..8).
- ADDR_W, 32, byte address width.
- LINE_BITS, 256, cacheline width in bits.
- PREFETCH_EN, 1, 1 = next-line prefetch buffer present; 0 = no prefetch logic.
- PF_PORT, 0, index of the port served by the prefetch buffer.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- port_read  in  NUM_PORTS  per-port read request, held until its port_resp.
- port_write  in  NUM_PORTS  per-port write request, held until its port_resp; read and write never both high on one port.
- port_addr  in  NUM_PORTS x ADDR_W  per-port byte address.
- port_wdata  in  NUM_PORTS x LINE_BITS  per-port write line.
- port_rdata  out  NUM_PORTS x LINE_BITS  per-port read line, valid only with port_resp.
- port_resp  out  NUM_PORTS  one-cycle completion pulse per port.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- mem_address  out  ADDR_W  line-aligned memory address.
- mem_wdata  out  LINE_BITS  memory write line.
- mem_rdata  in  LINE_BITS  memory read line, valid with mem_resp.
- mem_resp  in  1  memory completion pulse.

Behaviour:
- Reset values:
  - state=IDLE; mem_read=mem_write=0; mem_address=0; mem_wdata=0.
  - port_resp=0; port_rdata=0.
  - last_grant=NUM_PORTS-1, so port 0 wins first; pf_valid=0.
- Addresses are line-aligned: low log2(LINE_BITS/8) bits of mem_address are forced to 0.
- States:
  - IDLE: pick a port with read|write, searching from last_grant+1 with wrap-around. On a grant, register the port index, address, wdata and op.
    - Read on PF_PORT whose aligned address equals pf_addr while pf_valid=1: go to HIT.
    - Otherwise: go to SERVE.
    - No request and pf_pending=1: go to PREFETCH.
  - HIT: port_resp[g]=1 and port_rdata[g]=pf_data for exactly one cycle. last_grant<=g. Next state IDLE. No memory activity.
  - SERVE: mem_read or mem_write held with registered address/data until mem_resp.
    - On the mem_resp cycle: port_resp[g]=1, and for a read port_rdata[g]=mem_rdata (combinational pass). last_grant<=g. Next state IDLE.
    - A read on PF_PORT with PREFETCH_EN=1 also sets pf_pending=1 and pf_next=aligned addr+LINE_BITS/8, modulo 2^ADDR_W (wraps to 0).
  - PREFETCH: mem_read with pf_next until mem_resp. On mem_resp: pf_data<=mem_rdata, pf_addr<=pf_next, pf_valid<=1, pf_pending<=0. No port_resp. Next state IDLE.
- Latency:
  - Hit: grant in cycle N, resp in cycle N+1.
  - Miss: mem request asserted from cycle N+1, resp in the same cycle as mem_resp.
  - Requestor deasserts read/write the cycle after its resp; the arbiter re-arbitrates in that IDLE cycle.
- Demand priority: a demand request in IDLE always beats a pending prefetch. A prefetch already in progress is never aborted; demand waits for it.
- Coherence:
  - Any granted write whose aligned address equals pf_addr clears pf_valid in the grant cycle.
  - A write equal to pf_next during PREFETCH clears the incoming fill: pf_valid stays 0.
- Only one port_resp bit may be high in any cycle; port_rdata of non-responding ports is 0.
- Fairness: with all ports requesting continuously, each port is served once per NUM_PORTS transactions.
- PREFETCH_EN=0: HIT/PREFETCH unreachable; pf_* registers absent.
- rst mid-transaction: next cycle returns to reset values. The outstanding memory access is dropped and the memory model must tolerate a dropped request. No port_resp is issued for it.

Decomposition:
- Package cacheline_arbiter_pkg:
  - state enum {IDLE, SERVE, HIT, PREFETCH}.
  - function for line-offset bits from LINE_BITS.
  - function align_addr.
- Sub-module rr_grant: combinational round-robin picker. Inputs: request vector, last_grant. Outputs: grant_valid, grant_idx.

Test Plan:
- Single read, port 1, addr 0x0000_1044, memory resp after 4 cycles -> mem_address=0x0000_1040 in cycles 1-4; port_resp[1] with mem_rdata in the mem_resp cycle; port_resp[0]=0 throughout.
- Ports 0 and 1 both read continuously from reset -> grant order 0,1,0,1; never two resp bits in one cycle.
- Port 0 reads 0x0000_2000 -> after resp, PREFETCH reads 0x0000_2020 with no port_resp. A following port 0 read of 0x0000_2020 gives resp one cycle after grant with no mem_read.
- Port 1 writes 0x0000_2020 while pf_valid with pf_addr=0x0000_2020 -> pf_valid=0; next port 0 read of 0x0000_2020 goes to memory.
- Port 0 reads 0xFFFF_FFE0 -> pf_next=0x0000_0000 (wrap-around).
- rst asserted during SERVE with mem_read=1 -> next cycle mem_read=0, port_resp=0, pf_valid=0, and port 0 granted first afterwards.

Source files
------------

// File: rtl/cacheline_arbiter_pkg.sv
// Shared types and address helpers for the N-port cacheline arbiter.
// Address helpers work on a 64-bit container; callers truncate to ADDR_W.
package cacheline_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SERVE    = 2'd1,
    HIT      = 2'd2,
    PREFETCH = 2'd3
  } state_t;

  function automatic int line_off_bits(input int line_bits);
    return $clog2(line_bits / 8);
  endfunction

  function automatic logic [63:0] align_addr(input logic [63:0] addr, input int off_bits);
    logic [63:0] mask;
    mask = {64{1'b1}} << off_bits;
    return addr & mask;
  endfunction

endpackage

// File: rtl/cacheline_arbiter_rr_grant.sv
// Combinational round-robin picker: first requester after last_grant, wrapping.
module rr_grant #(
  parameter int NUM_PORTS = 2,
  parameter int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     last_grant,
  output logic                 grant_valid,
  output logic [IDX_W-1:0]     grant_idx
);

  always_comb begin
    int idx;
    idx         = 0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      idx = (int'(last_grant) + i) % NUM_PORTS;
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/cacheline_arbiter.sv
// N-port cacheline arbiter in front of one memory port, with an optional
// one-line next-line prefetch buffer serving port PF_PORT.
//
// state    | meaning
// IDLE     | arbitrate demand requests; otherwise launch a pending prefetch
// SERVE    | granted demand access running on the memory port
// HIT      | granted read answered from the prefetch buffer
// PREFETCH | next-line fill running on the memory port
module cacheline_arbiter
  import cacheline_arbiter_pkg::*;
#(
  parameter int NUM_PORTS   = 2,
  parameter int ADDR_W      = 32,
  parameter int LINE_BITS   = 256,
  parameter int PREFETCH_EN = 1,
  parameter int PF_PORT     = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_PORTS-1:0]           port_read,
  input  logic [NUM_PORTS-1:0]           port_write,
  input  logic [NUM_PORTS*ADDR_W-1:0]    port_addr,
  input  logic [NUM_PORTS*LINE_BITS-1:0] port_wdata,
  output logic [NUM_PORTS*LINE_BITS-1:0] port_rdata,
  output logic [NUM_PORTS-1:0]           port_resp,
  output logic                           mem_read,
  output logic                           mem_write,
  output logic [ADDR_W-1:0]              mem_address,
  output logic [LINE_BITS-1:0]           mem_wdata,
  input  logic [LINE_BITS-1:0]           mem_rdata,
  input  logic                           mem_resp
);

  localparam int                IDX_W      = $clog2(NUM_PORTS);
  localparam int                OFF_BITS   = line_off_bits(LINE_BITS);
  localparam logic [ADDR_W-1:0] LINE_BYTES = ADDR_W'(LINE_BITS / 8);
  localparam logic [IDX_W-1:0]  PF_IDX     = IDX_W'(PF_PORT);
  localparam bit                PF_ON      = (PREFETCH_EN != 0);

  function automatic logic [ADDR_W-1:0] line_addr(input logic [ADDR_W-1:0] a);
    return ADDR_W'(align_addr(64'(a), OFF_BITS));
  endfunction

  state_t               state;
  logic [IDX_W-1:0]     last_grant;
  logic [IDX_W-1:0]     g_idx;
  logic                 g_read;

  logic                 pf_valid;
  logic                 pf_pending;
  logic                 pf_kill;
  logic [ADDR_W-1:0]    pf_addr;
  logic [ADDR_W-1:0]    pf_next;
  logic [LINE_BITS-1:0] pf_data;

  logic                 gnt_valid;
  logic [IDX_W-1:0]     gnt_idx;
  logic                 gnt_read;
  logic [ADDR_W-1:0]    sel_addr;
  logic [LINE_BITS-1:0] sel_wdata;
  logic                 pf_hit_grant;
  logic                 wr_kill_now;

  rr_grant #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_rr_grant (
    .req         (port_read | port_write),
    .last_grant  (last_grant),
    .grant_valid (gnt_valid),
    .grant_idx   (gnt_idx)
  );

  assign gnt_read     = port_read[gnt_idx];
  assign sel_addr     = line_addr(port_addr[int'(gnt_idx)*ADDR_W +: ADDR_W]);
  assign sel_wdata    = port_wdata[int'(gnt_idx)*LINE_BITS +: LINE_BITS];
  assign pf_hit_grant = PF_ON && pf_valid && gnt_read && (gnt_idx == PF_IDX) && (sel_addr == pf_addr);

  // Any port waiting to write the line being fetched poisons the fill.
  always_comb begin
    wr_kill_now = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (port_write[i] && (line_addr(port_addr[i*ADDR_W +: ADDR_W]) == pf_next))
        wr_kill_now = 1'b1;
    end
  end

  // Completion is combinational on mem_resp so the read line passes straight through.
  always_comb begin
    port_resp  = '0;
    port_rdata = '0;
    if (state == HIT) begin
      port_resp[g_idx]                                 = 1'b1;
      port_rdata[int'(g_idx)*LINE_BITS +: LINE_BITS]   = pf_data;
    end else if (state == SERVE && mem_resp) begin
      port_resp[g_idx] = 1'b1;
      if (g_read)
        port_rdata[int'(g_idx)*LINE_BITS +: LINE_BITS] = mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_address <= '0;
      mem_wdata   <= '0;
      last_grant  <= IDX_W'(NUM_PORTS - 1);
      g_idx       <= '0;
      g_read      <= 1'b0;
      pf_valid    <= 1'b0;
      pf_pending  <= 1'b0;
      pf_kill     <= 1'b0;
      pf_addr     <= '0;
      pf_next     <= '0;
      pf_data     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (gnt_valid) begin
            g_idx       <= gnt_idx;
            g_read      <= gnt_read;
            mem_address <= sel_addr;
            mem_wdata   <= sel_wdata;
            if (PF_ON && !gnt_read && (sel_addr == pf_addr))
              pf_valid <= 1'b0;
            if (pf_hit_grant) begin
              state <= HIT;
            end else begin
              state     <= SERVE;
              mem_read  <= gnt_read;
              mem_write <= !gnt_read;
            end
          end else if (PF_ON && pf_pending) begin
            state       <= PREFETCH;
            mem_read    <= 1'b1;
            mem_address <= pf_next;
            pf_kill     <= 1'b0;
          end
        end

        HIT: begin
          last_grant <= g_idx;
          state      <= IDLE;
        end

        SERVE: begin
          if (mem_resp) begin
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            last_grant <= g_idx;
            state      <= IDLE;
            if (PF_ON && g_read && (g_idx == PF_IDX)) begin
              pf_pending <= 1'b1;
              pf_next    <= mem_address + LINE_BYTES;
            end
          end
        end

        PREFETCH: begin
          if (wr_kill_now)
            pf_kill <= 1'b1;
          if (mem_resp) begin
            mem_read   <= 1'b0;
            pf_pending <= 1'b0;
            state      <= IDLE;
            if (pf_kill || wr_kill_now) begin
              pf_valid <= 1'b0;
            end else begin
              pf_data  <= mem_rdata;
              pf_addr  <= pf_next;
              pf_valid <= 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cacheline_arbiter.sv
// Self-checking bench for cacheline_arbiter: directed scenarios plus a random
// two-port run checked against a line-granular memory image.
module tb_cacheline_arbiter;

  localparam int NP = 2;
  localparam int AW = 32;
  localparam int LB = 256;

  logic            clk;
  logic            rst;
  logic [NP-1:0]   port_read, port_write, port_resp;
  logic [NP*AW-1:0] port_addr;
  logic [NP*LB-1:0] port_wdata, port_rdata;
  logic            mem_read, mem_write, mem_resp;
  logic [AW-1:0]   mem_address;
  logic [LB-1:0]   mem_wdata, mem_rdata;

  int errors = 0;
  int checks = 0;
  int lat_cfg = 2;
  bit rand_lat = 0;
  int m_cnt = 0;
  int m_cur = 1;
  logic [LB-1:0] mem_model [logic [AW-1:0]];

  cacheline_arbiter #(
    .NUM_PORTS   (NP),
    .ADDR_W      (AW),
    .LINE_BITS   (LB),
    .PREFETCH_EN (1),
    .PF_PORT     (0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .port_read   (port_read),
    .port_write  (port_write),
    .port_addr   (port_addr),
    .port_wdata  (port_wdata),
    .port_rdata  (port_rdata),
    .port_resp   (port_resp),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_address (mem_address),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_resp    (mem_resp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [AW-1:0] align(input logic [AW-1:0] a);
    return {a[AW-1:5], 5'b00000};
  endfunction

  function automatic logic [LB-1:0] pat_line(input logic [AW-1:0] a);
    logic [LB-1:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = a ^ 32'(32'h9E37_79B9 * (i + 1));
    return r;
  endfunction

  function automatic logic [LB-1:0] model_line(input logic [AW-1:0] a);
    if (mem_model.exists(align(a))) return mem_model[align(a)];
    return pat_line(align(a));
  endfunction

  function automatic logic [LB-1:0] rand_line();
    logic [LB-1:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  function automatic logic [LB-1:0] rdata_of(input int p);
    return port_rdata[p*LB +: LB];
  endfunction

  // Memory: answers after a per-access latency, drops work on reset.
  initial begin
    mem_resp  = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      mem_resp = 1'b0;
      if (rst || !(mem_read || mem_write)) begin
        m_cnt = 0;
      end else begin
        if (m_cnt == 0) m_cur = rand_lat ? int'($urandom_range(1, 4)) : lat_cfg;
        m_cnt++;
        if (m_cnt >= m_cur) begin
          mem_resp = 1'b1;
          m_cnt    = 0;
          if (mem_write) mem_model[mem_address] = mem_wdata;
          else           mem_rdata = model_line(mem_address);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input bit rd, input bit wr,
                         input logic [AW-1:0] a, input logic [LB-1:0] d);
    port_read[p]          = rd;
    port_write[p]         = wr;
    port_addr[p*AW +: AW] = a;
    port_wdata[p*LB +: LB] = d;
  endtask

  task automatic apply_reset();
    for (int p = 0; p < NP; p++) set_req(p, 0, 0, '0, '0);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // One transaction from IDLE; cyc counts cycles from the grant cycle to resp.
  task automatic do_txn(input int p, input bit rd, input logic [AW-1:0] a, input logic [LB-1:0] d,
                        output int cyc, output bit saw_mem, output logic [LB-1:0] rdat,
                        output logic [AW-1:0] maddr);
    int n;
    bit done;
    n = 0; done = 0; cyc = -1; saw_mem = 0; rdat = '0; maddr = '0;
    set_req(p, rd, !rd, a, d);
    while (!done && n < 60) begin
      @(negedge clk);
      if (n > 0 && (mem_read || mem_write)) begin
        saw_mem = 1;
        maddr   = mem_address;
      end
      if (port_resp[p]) begin
        done = 1;
        cyc  = n;
        rdat = rdata_of(p);
      end
      step();
      n++;
    end
    set_req(p, 0, 0, a, d);
  endtask

  task automatic wait_quiet(output bit ok);
    int q;
    q = 0; ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (mem_read || mem_write) q = 0;
      else q++;
      if (q >= 3) ok = 1;
      step();
    end
  endtask

  task automatic watch_prefetch(output bit seen, output logic [AW-1:0] pa, output bit any_resp);
    int q;
    q = 0; seen = 0; pa = '0; any_resp = 0;
    for (int i = 0; i < 40 && !(seen && q >= 2); i++) begin
      @(negedge clk);
      if (port_resp != '0) any_resp = 1;
      if (mem_read) begin
        seen = 1;
        pa   = mem_address;
      end else if (seen) q++;
      step();
    end
  endtask

  task automatic test_reset();
    for (int p = 0; p < NP; p++) set_req(p, 0, 0, '0, '0);
    rst = 1'b1;
    step();
    step();
    @(negedge clk);
    checks++; if (mem_read !== 1'b0)  begin errors++; $display("FAIL reset_mem_read: got %b expected 0", mem_read); end
    checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL reset_mem_write: got %b expected 0", mem_write); end
    checks++; if (mem_address !== '0) begin errors++; $display("FAIL reset_mem_address: got %h expected 0", mem_address); end
    checks++; if (mem_wdata !== '0)   begin errors++; $display("FAIL reset_mem_wdata: got %h expected 0", mem_wdata); end
    checks++; if (port_resp !== '0)   begin errors++; $display("FAIL reset_port_resp: got %b expected 0", port_resp); end
    checks++; if (port_rdata !== '0)  begin errors++; $display("FAIL reset_port_rdata: nonzero, expected 0"); end
    step();
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    logic [1:0] exp_resp;
    bit ok;
    lat_cfg = 4;
    set_req(1, 1, 0, 32'h0000_1044, '0);
    @(negedge clk);
    checks++; if (mem_read !== 1'b0 || port_resp !== 2'b00) begin
      errors++; $display("FAIL single_grant_cycle: mem_read=%b resp=%b expected 0/00", mem_read, port_resp);
    end
    for (int c = 1; c <= 4; c++) begin
      step();
      @(negedge clk);
      checks++; if (mem_read !== 1'b1 || mem_address !== 32'h0000_1040) begin
        errors++; $display("FAIL single_mem_req c%0d: read=%b addr=%h expected 1/00001040", c, mem_read, mem_address);
      end
      exp_resp = (c == 4) ? 2'b10 : 2'b00;
      checks++; if (port_resp !== exp_resp) begin
        errors++; $display("FAIL single_resp c%0d: got %b expected %b", c, port_resp, exp_resp);
      end
    end
    checks++; if (rdata_of(1) !== model_line(32'h0000_1040)) begin
      errors++; $display("FAIL single_rdata: got %h expected %h", rdata_of(1), model_line(32'h0000_1040));
    end
    checks++; if (rdata_of(0) !== '0) begin
      errors++; $display("FAIL single_idle_rdata: got %h expected 0", rdata_of(0));
    end
    step();
    set_req(1, 0, 0, '0, '0);
    wait_quiet(ok);
  endtask

  task automatic test_round_robin();
    int order[$];
    bit off[NP];
    bit raise[NP];
    logic [AW-1:0] cur[NP];
    int n;
    bit ok;
    apply_reset();
    lat_cfg = 2;
    cur[0] = 32'h0000_3000;
    cur[1] = 32'h0000_5000;
    for (int p = 0; p < NP; p++) begin
      off[p] = 0; raise[p] = 0;
      set_req(p, 1, 0, cur[p], '0);
    end
    n = 0;
    while (order.size() < 8 && n < 200) begin
      @(negedge clk);
      checks++; if ($countones(port_resp) > 1) begin
        errors++; $display("FAIL rr_onehot: resp=%b expected at most one bit", port_resp);
      end
      for (int p = 0; p < NP; p++) begin
        if (port_resp[p]) begin
          order.push_back(p);
          off[p] = 1;
          checks++; if (rdata_of(p) !== model_line(cur[p])) begin
            errors++; $display("FAIL rr_rdata p%0d: got %h expected %h", p, rdata_of(p), model_line(cur[p]));
          end
        end
      end
      step();
      n++;
      for (int p = 0; p < NP; p++) begin
        if (off[p]) begin
          set_req(p, 0, 0, cur[p], '0);
          off[p] = 0; raise[p] = 1;
          cur[p] = cur[p] + 32'h100;
        end else if (raise[p]) begin
          set_req(p, 1, 0, cur[p], '0);
          raise[p] = 0;
        end
      end
    end
    checks++; if (order.size() != 8) begin
      errors++; $display("FAIL rr_count: got %0d responses expected 8", order.size());
    end
    for (int i = 0; i < order.size(); i++) begin
      checks++; if (order[i] != i % 2) begin
        errors++; $display("FAIL rr_order[%0d]: got port %0d expected port %0d", i, order[i], i % 2);
      end
    end
    for (int p = 0; p < NP; p++) set_req(p, 0, 0, '0, '0);
    wait_quiet(ok);
  endtask

  task automatic test_prefetch();
    int cyc;
    bit saw, seen, anyr;
    logic [LB-1:0] rd;
    logic [AW-1:0] ma, pa;
    apply_reset();
    lat_cfg = 2;
    do_txn(0, 1, 32'h0000_2000, '0, cyc, saw, rd, ma);
    checks++; if (cyc != 2 || rd !== model_line(32'h0000_2000)) begin
      errors++; $display("FAIL pf_first_read: cyc=%0d expected 2, data %h expected %h", cyc, rd, model_line(32'h0000_2000));
    end
    watch_prefetch(seen, pa, anyr);
    checks++; if (!seen || pa !== 32'h0000_2020) begin
      errors++; $display("FAIL pf_fetch_addr: seen=%b addr=%h expected 1/00002020", seen, pa);
    end
    checks++; if (anyr) begin
      errors++; $display("FAIL pf_no_resp: got port_resp during prefetch expected none");
    end
    do_txn(0, 1, 32'h0000_2020, '0, cyc, saw, rd, ma);
    checks++; if (cyc != 1 || saw) begin
      errors++; $display("FAIL pf_hit_latency: cyc=%0d mem=%b expected 1/0", cyc, saw);
    end
    checks++; if (rd !== model_line(32'h0000_2020)) begin
      errors++; $display("FAIL pf_hit_data: got %h expected %h", rd, model_line(32'h0000_2020));
    end
  endtask

  task automatic test_write_invalidate();
    int cyc;
    bit saw, ok;
    logic [LB-1:0] rd, wd;
    logic [AW-1:0] ma;
    wd = rand_line();
    do_txn(1, 0, 32'h0000_2020, wd, cyc, saw, rd, ma);
    checks++; if (cyc != 2 || !saw || ma !== 32'h0000_2020) begin
      errors++; $display("FAIL inv_write: cyc=%0d mem=%b addr=%h expected 2/1/00002020", cyc, saw, ma);
    end
    do_txn(0, 1, 32'h0000_2024, '0, cyc, saw, rd, ma);
    checks++; if (!saw || ma !== 32'h0000_2020 || cyc != 2) begin
      errors++; $display("FAIL inv_read_miss: mem=%b addr=%h cyc=%0d expected 1/00002020/2", saw, ma, cyc);
    end
    checks++; if (rd !== wd) begin
      errors++; $display("FAIL inv_read_data: got %h expected %h", rd, wd);
    end
    wait_quiet(ok);
  endtask

  task automatic test_wrap();
    int cyc;
    bit saw, seen, anyr;
    logic [LB-1:0] rd;
    logic [AW-1:0] ma, pa;
    do_txn(0, 1, 32'hFFFF_FFE0, '0, cyc, saw, rd, ma);
    checks++; if (rd !== model_line(32'hFFFF_FFE0)) begin
      errors++; $display("FAIL wrap_read: got %h expected %h", rd, model_line(32'hFFFF_FFE0));
    end
    watch_prefetch(seen, pa, anyr);
    checks++; if (!seen || pa !== 32'h0000_0000) begin
      errors++; $display("FAIL wrap_pf_addr: seen=%b addr=%h expected 1/00000000", seen, pa);
    end
    do_txn(0, 1, 32'h0000_0004, '0, cyc, saw, rd, ma);
    checks++; if (cyc != 1 || saw || rd !== model_line(32'h0)) begin
      errors++; $display("FAIL wrap_hit: cyc=%0d mem=%b data %h expected 1/0/%h", cyc, saw, rd, model_line(32'h0));
    end
  endtask

  task automatic test_no_abort();
    int cyc;
    bit saw, found, ok;
    logic [LB-1:0] rd, wd;
    logic [AW-1:0] ma;
    lat_cfg = 4;
    wd = rand_line();
    do_txn(0, 1, 32'h0000_4000, '0, cyc, saw, rd, ma);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (mem_read && mem_address === 32'h0000_4020) found = 1;
      step();
    end
    checks++; if (!found) begin
      errors++; $display("FAIL noabort_pf_start: prefetch of 00004020 not seen within 20 cycles");
    end
    // Write raised in the second prefetch cycle: 3 more cycles of fill, IDLE, then 4 SERVE cycles.
    do_txn(1, 0, 32'h0000_4020, wd, cyc, saw, rd, ma);
    checks++; if (cyc != 7) begin
      errors++; $display("FAIL noabort_wait: write resp after %0d cycles expected 7", cyc);
    end
    do_txn(0, 1, 32'h0000_4020, '0, cyc, saw, rd, ma);
    checks++; if (!saw || rd !== wd) begin
      errors++; $display("FAIL noabort_read_after_write: mem=%b data %h expected 1/%h", saw, rd, wd);
    end
    lat_cfg = 2;
    wait_quiet(ok);
  endtask

  task automatic test_reset_mid();
    int cyc, first;
    bit saw, seen, anyr, got0, got1, saw7020;
    logic [LB-1:0] rd;
    logic [AW-1:0] ma, pa;
    lat_cfg = 2;
    do_txn(0, 1, 32'h0000_7000, '0, cyc, saw, rd, ma);
    watch_prefetch(seen, pa, anyr);
    lat_cfg = 10;
    set_req(0, 1, 0, 32'h0000_6000, '0);
    step();
    step();
    @(negedge clk);
    checks++; if (mem_read !== 1'b1) begin
      errors++; $display("FAIL rstmid_serving: mem_read=%b expected 1", mem_read);
    end
    step();
    rst = 1'b1;
    set_req(0, 0, 0, '0, '0);
    step();
    @(negedge clk);
    checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0 || port_resp !== '0) begin
      errors++; $display("FAIL rstmid_cleared: read=%b write=%b resp=%b expected 0/0/00", mem_read, mem_write, port_resp);
    end
    step();
    rst = 1'b0;
    lat_cfg = 2;
    set_req(0, 1, 0, 32'h0000_7020, '0);
    set_req(1, 1, 0, 32'h0000_8000, '0);
    got0 = 0; got1 = 0; first = -1; saw7020 = 0;
    for (int i = 0; i < 60 && !(got0 && got1); i++) begin
      @(negedge clk);
      if (mem_read && mem_address === 32'h0000_7020) saw7020 = 1;
      if (port_resp[0] && !got0) begin got0 = 1; if (first < 0) first = 0; end
      if (port_resp[1] && !got1) begin got1 = 1; if (first < 0) first = 1; end
      step();
      if (got0) set_req(0, 0, 0, '0, '0);
      if (got1) set_req(1, 0, 0, '0, '0);
    end
    checks++; if (first != 0 || !got0 || !got1) begin
      errors++; $display("FAIL rstmid_first_grant: first=%0d got0=%b got1=%b expected 0/1/1", first, got0, got1);
    end
    checks++; if (!saw7020) begin
      errors++; $display("FAIL rstmid_pf_invalid: read of 00007020 not sent to memory, expected miss");
    end
    for (int p = 0; p < NP; p++) set_req(p, 0, 0, '0, '0);
  endtask

  task automatic test_random();
    bit busy[NP], drop[NP], isrd[NP], starve[NP];
    logic [AW-1:0] addr[NP];
    int waitc[NP];
    int nresp;
    bit ok;
    rand_lat = 1;
    nresp = 0;
    for (int p = 0; p < NP; p++) begin
      busy[p] = 0; drop[p] = 0; isrd[p] = 0; starve[p] = 0; waitc[p] = 0; addr[p] = '0;
    end
    for (int c = 0; c < 600; c++) begin
      for (int p = 0; p < NP; p++) begin
        if (drop[p]) begin
          set_req(p, 0, 0, addr[p], '0);
          drop[p] = 0; busy[p] = 0;
        end else if (!busy[p] && $urandom_range(0, 2) != 0) begin
          busy[p]  = 1;
          waitc[p] = 0;
          isrd[p]  = ($urandom_range(0, 9) < 7);
          addr[p]  = 32'h0000_9000 + 32'($urandom_range(0, 5)) * 32 + 32'($urandom_range(0, 31));
          set_req(p, isrd[p], !isrd[p], addr[p], rand_line());
        end
      end
      @(negedge clk);
      checks++; if ($countones(port_resp) > 1) begin
        errors++; $display("FAIL rand_onehot: resp=%b expected at most one bit", port_resp);
      end
      for (int p = 0; p < NP; p++) begin
        if (port_resp[p]) begin
          nresp++;
          checks++; if (!busy[p]) begin
            errors++; $display("FAIL rand_spurious p%0d: resp without request", p);
          end else if (isrd[p] && rdata_of(p) !== model_line(addr[p])) begin
            errors++; $display("FAIL rand_rdata p%0d addr %h: got %h expected %h", p, addr[p], rdata_of(p), model_line(addr[p]));
          end
          drop[p] = 1;
        end else begin
          checks++; if (rdata_of(p) !== '0) begin
            errors++; $display("FAIL rand_idle_rdata p%0d: got %h expected 0", p, rdata_of(p));
          end
          if (busy[p]) waitc[p]++;
          if (waitc[p] > 80 && !starve[p]) begin
            starve[p] = 1;
            checks++; errors++;
            $display("FAIL rand_starve p%0d: waited %0d cycles expected at most 80", p, waitc[p]);
          end
        end
      end
      step();
    end
    checks++; if (nresp < 40) begin
      errors++; $display("FAIL rand_progress: got %0d responses expected at least 40", nresp);
    end
    for (int p = 0; p < NP; p++) set_req(p, 0, 0, '0, '0);
    rand_lat = 0;
    wait_quiet(ok);
  endtask

  initial begin
    rst        = 1'b1;
    port_read  = '0;
    port_write = '0;
    port_addr  = '0;
    port_wdata = '0;
    test_reset();
    test_single_read();
    test_round_robin();
    test_prefetch();
    test_write_invalidate();
    test_wrap();
    test_no_abort();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
